// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: FSM encoding and
// data-port command codes.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACC_IF = 2'b01,
        ST_ACC_D  = 2'b10
    } state_t;

    localparam logic [1:0] RW_WRITE = 2'b01;
    localparam logic [1:0] RW_READ  = 2'b10;
    localparam logic [1:0] RW_IDLE  = 2'b11;

    function automatic logic is_data_req(input logic [1:0] rw);
        return (rw == RW_WRITE) || (rw == RW_READ);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the 32-bit data port and the word-addressed RAM,
// plus detection of write masks that would spill past the top lane.
module mem_lane_align (
    input  logic [1:0]  wr_off,
    input  logic [3:0]  sel,
    input  logic [31:0] wdata,
    input  logic [1:0]  rd_off,
    input  logic [31:0] rdata,
    output logic [3:0]  we,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_sh,
    output logic        misaligned
);

    logic [7:0] sel_wide;

    always_comb begin
        // Widen before shifting so lanes pushed past bit 3 stay visible.
        sel_wide   = {4'b0000, sel} << wr_off;
        we         = sel_wide[3:0];
        misaligned = |sel_wide[7:4];
        wdata_sh   = wdata << {wr_off, 3'b000};
        rdata_sh   = rdata >> {rd_off, 3'b000};
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported word RAM: data accesses win,
// except that a waiting fetch is forced through after STARVE_MAX data grants.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [11:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic [1:0]  d_rw,
    input  logic [11:0] d_addr,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        d_err,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [9:0]  ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        stall_req
);

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t      state, state_next;
    logic [2:0]  starve_cnt;
    logic        err_q;
    logic [1:0]  off_q;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;

    logic        grant_if, grant_d, err_now;
    logic        d_req, d_write;
    logic [3:0]  lane_we;
    logic [31:0] lane_wdata, lane_rdata;
    logic        misaligned;

    // Fetches are whole words; the byte offset bits carry no meaning here.
    logic        if_addr_unused;
    assign if_addr_unused = ^if_addr[1:0];

    mem_lane_align u_align (
        .wr_off     (d_addr[1:0]),
        .sel        (d_sel),
        .wdata      (d_wdata),
        .rd_off     (off_q),
        .rdata      (ram_rdata),
        .we         (lane_we),
        .wdata_sh   (lane_wdata),
        .rdata_sh   (lane_rdata),
        .misaligned (misaligned)
    );

    // A request whose error pulse is showing this cycle must not be seen again.
    assign d_req   = is_data_req(d_rw) && !err_q;
    assign d_write = (d_rw == RW_WRITE);

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process evaluation order.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_next = state;
        grant_if   = 1'b0;
        grant_d    = 1'b0;
        err_now    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rst) begin
                    if (if_req && (starve_cnt == STARVE_LIM || !d_req)) begin
                        grant_if   = 1'b1;
                        state_next = ST_ACC_IF;
                    end else if (d_req) begin
                        if (d_write && misaligned) begin
                            err_now = 1'b1;
                        end else begin
                            grant_d    = 1'b1;
                            state_next = ST_ACC_D;
                        end
                    end
                end
            end
            ST_ACC_IF: state_next = ST_IDLE;
            ST_ACC_D:  state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_en    = grant_if | grant_d;
        ram_we    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (grant_if) begin
            ram_addr = if_addr[11:2];
        end else if (grant_d) begin
            ram_addr = d_addr[11:2];
            if (d_write) begin
                ram_we    = lane_we;
                ram_wdata = lane_wdata;
            end
        end
        // NOTE: completion strobes are masked while rst is high so an access
        // interrupted by reset never reports completion.
        if_ready  = (state == ST_ACC_IF) && !rst;
        d_ready   = ((state == ST_ACC_D) || err_q) && !rst;
        d_err     = err_q && !rst;
        if_rdata  = (state == ST_ACC_IF) ? ram_rdata  : if_rdata_q;
        d_rdata   = (state == ST_ACC_D)  ? lane_rdata : d_rdata_q;
        stall_req = is_data_req(d_rw) && !d_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            err_q      <= 1'b0;
            off_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            err_q <= err_now;
            if (grant_d) begin
                off_q <= d_addr[1:0];
            end
            if (state == ST_ACC_IF) begin
                if_rdata_q <= ram_rdata;
            end
            if (state == ST_ACC_D) begin
                d_rdata_q <= lane_rdata;
            end
            if (!if_req || grant_if) begin
                starve_cnt <= '0;
            end else if (grant_d && starve_cnt < STARVE_LIM) begin
                starve_cnt <= starve_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed timing scenarios, then random
// traffic on both ports checked against a byte-level memory model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [11:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic [1:0]  d_rw;
    logic [11:0] d_addr;
    logic [3:0]  d_sel;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_err;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        stall_req;

    typedef struct {
        bit          is_read;
        bit          err;
        logic [31:0] rdata;
    } d_exp_t;

    d_exp_t      d_q[$];
    logic [31:0] f_q[$];
    logic [31:0] ram_mem[1024];
    logic [31:0] ref_mem[1024];
    int          total = 0;
    int          bad   = 0;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_rw      (d_rw),
        .d_addr    (d_addr),
        .d_sel     (d_sel),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .d_err     (d_err),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .stall_req (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pattern(input int i);
        return (i * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // RAM environment: read data appears the cycle after ram_en.
    initial begin
        for (int i = 0; i < 1024; i++) ram_mem[i] = pattern(i);
        ram_rdata = '0;
        forever begin
            @(posedge clk);
            if (ram_en) begin
                ram_rdata <= ram_mem[ram_addr];
                for (int b = 0; b < 4; b++)
                    if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no response want response within bound", name);
    endtask

    // Reference model: byte-addressed memory, writes land on lanes off..off+3.
    function automatic d_exp_t model_data(input logic [1:0] rw, input logic [11:0] addr,
                                          input logic [3:0] sel, input logic [31:0] wdata);
        d_exp_t e;
        int word = int'(addr[11:2]);
        int off  = int'(addr[1:0]);
        e.rdata = '0;
        if (rw == RW_READ) begin
            e.is_read = 1'b1;
            e.err     = 1'b0;
            e.rdata   = ref_mem[word] >> (8 * off);
        end else begin
            e.is_read = 1'b0;
            e.err     = ((int'(sel) << off) > 15);
            if (!e.err)
                for (int b = 0; b < 4; b++)
                    if (sel[b]) ref_mem[word][8*(b+off) +: 8] = wdata[8*b +: 8];
        end
        return e;
    endfunction

    // Monitor: pops the scoreboard whenever a port reports completion.
    initial begin
        d_exp_t e;
        logic [31:0] f;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (d_ready) begin
                    if (d_q.size() == 0) check("d_ready_unexpected", d_ready, 1'b0);
                    else begin
                        e = d_q.pop_front();
                        check("d_err", d_err, e.err);
                        if (e.is_read) check("d_rdata", d_rdata, e.rdata);
                    end
                end
                if (if_ready) begin
                    if (f_q.size() == 0) check("if_ready_unexpected", if_ready, 1'b0);
                    else begin
                        f = f_q.pop_front();
                        check("if_rdata", if_rdata, f);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Data transaction; called just after a rising edge. Inputs are
    // scrambled after the grant to prove they were captured.
    task automatic data_txn(input logic [1:0] rw, input logic [11:0] addr,
                            input logic [3:0] sel, input logic [31:0] wdata);
        bit granted = 1'b0;
        bit done    = 1'b0;
        d_q.push_back(model_data(rw, addr, sel, wdata));
        d_rw = rw; d_addr = addr; d_sel = sel; d_wdata = wdata;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (d_ready) done = 1'b1;
            else if (!granted && ram_en && ram_addr == addr[11:2]) begin
                granted = 1'b1;
                step();
                d_addr[1:0] = 2'($urandom);
                d_sel       = 4'($urandom);
                d_wdata     = $urandom;
            end
        end
        if (!done) timeout_fail("data_ready");
        step();
        d_rw = RW_IDLE;
    endtask

    task automatic fetch_txn(input logic [11:0] addr);
        bit done = 1'b0;
        f_q.push_back(ref_mem[addr[11:2]]);
        if_addr = addr;
        if_req  = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (if_ready) done = 1'b1;
        end
        if (!done) timeout_fail("if_ready");
        step();
        if_req = 1'b0;
    endtask

    initial begin
        logic [9:0] grants[10];
        int ng;
        int nbad;

        for (int i = 0; i < 1024; i++) ref_mem[i] = pattern(i);
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        d_rw = RW_IDLE; d_addr = '0; d_sel = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ram_en", ram_en, 1'b0);
        check("rst_ram_we", ram_we, 4'h0);
        check("rst_d_ready", d_ready, 1'b0);
        check("rst_if_ready", if_ready, 1'b0);
        check("rst_d_err", d_err, 1'b0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_stall", stall_req, 1'b0);

        // Byte write into lane 1
        step();
        d_q.push_back(model_data(RW_WRITE, 12'h005, 4'b0001, 32'h0000_00AB));
        d_rw = RW_WRITE; d_addr = 12'h005; d_sel = 4'b0001; d_wdata = 32'h0000_00AB;
        @(negedge clk);
        check("wr_ram_en", ram_en, 1'b1);
        check("wr_ram_we", ram_we, 4'b0010);
        check("wr_ram_wdata", ram_wdata, 32'h0000_AB00);
        check("wr_ram_addr", ram_addr, 10'h001);
        check("wr_stall_grant", stall_req, 1'b1);
        check("wr_ready_grant", d_ready, 1'b0);
        @(negedge clk);
        check("wr_ready", d_ready, 1'b1);
        check("wr_stall_ready", stall_req, 1'b0);
        check("wr_ram_en_ready", ram_en, 1'b0);
        step();
        d_rw = RW_IDLE;

        // Full-word write, then half-word read at offset 2
        data_txn(RW_WRITE, 12'h004, 4'b1111, 32'h1234_5678);
        d_q.push_back(model_data(RW_READ, 12'h006, 4'b0000, 32'h0));
        d_rw = RW_READ; d_addr = 12'h006;
        @(negedge clk);
        check("rd_stall_grant", stall_req, 1'b1);
        check("rd_ram_we", ram_we, 4'h0);
        @(negedge clk);
        check("rd_ready", d_ready, 1'b1);
        check("rd_rdata", d_rdata, 32'h0000_1234);
        check("rd_stall_ready", stall_req, 1'b0);
        step();
        d_rw = RW_IDLE;
        @(negedge clk);
        check("rd_rdata_hold", d_rdata, 32'h0000_1234);

        // Misaligned word write
        step();
        d_q.push_back(model_data(RW_WRITE, 12'h002, 4'b1111, 32'hDEAD_BEEF));
        d_rw = RW_WRITE; d_addr = 12'h002; d_sel = 4'b1111; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("mis_ram_en_req", ram_en, 1'b0);
        check("mis_ready_req", d_ready, 1'b0);
        @(negedge clk);
        check("mis_err", d_err, 1'b1);
        check("mis_ready", d_ready, 1'b1);
        check("mis_ram_en_pulse", ram_en, 1'b0);
        step();
        d_rw = RW_IDLE;
        @(negedge clk);
        check("mis_err_clear", d_err, 1'b0);

        // Simultaneous requests with empty starvation count
        step();
        d_q.push_back(model_data(RW_READ, 12'h010, 4'b0000, 32'h0));
        f_q.push_back(ref_mem[512]);
        if_req = 1'b1; if_addr = 12'h800;
        d_rw = RW_READ; d_addr = 12'h010;
        @(negedge clk);
        check("sim_first_addr", ram_addr, 10'd4);
        @(negedge clk);
        check("sim_d_ready", d_ready, 1'b1);
        check("sim_no_regrant", ram_en, 1'b0);
        step();
        d_rw = RW_IDLE;
        @(negedge clk);
        check("sim_fetch_en", ram_en, 1'b1);
        check("sim_fetch_addr", ram_addr, 10'd512);
        @(negedge clk);
        check("sim_if_ready", if_ready, 1'b1);
        step();
        if_req = 1'b0;

        // Starvation: continuous reads with a fetch always pending
        step();
        for (int i = 0; i < 8; i++) d_q.push_back(model_data(RW_READ, 12'h020, 4'b0000, 32'h0));
        f_q.push_back(ref_mem[513]);
        f_q.push_back(ref_mem[513]);
        if_req = 1'b1; if_addr = 12'h804;
        d_rw = RW_READ; d_addr = 12'h020;
        ng = 0;
        for (int i = 0; i < 60 && ng < 10; i++) begin
            @(negedge clk);
            if (ram_en) begin
                grants[ng] = ram_addr;
                ng++;
            end
        end
        if (ng < 10) timeout_fail("starve_grants");
        else begin
            for (int i = 0; i < 10; i++)
                check($sformatf("starve_grant%0d", i), grants[i],
                      ((i % (STARVE_MAX + 1)) == STARVE_MAX) ? 10'd513 : 10'd8);
            @(negedge clk);
        end
        step();
        if_req = 1'b0; d_rw = RW_IDLE;

        // Reset during the data access cycle
        step();
        d_rw = RW_READ; d_addr = 12'h030;
        @(negedge clk);
        check("rstacc_grant", ram_en, 1'b1);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("rstacc_no_ready", d_ready, 1'b0);
        step();
        rst = 1'b0; d_rw = RW_IDLE;
        @(negedge clk);
        check("rstacc_ram_en", ram_en, 1'b0);
        check("rstacc_d_ready", d_ready, 1'b0);
        check("rstacc_if_ready", if_ready, 1'b0);
        check("rstacc_d_err", d_err, 1'b0);
        check("rstacc_d_rdata", d_rdata, 32'h0);
        check("rstacc_if_rdata", if_rdata, 32'h0);

        // Random traffic: data in words 0..255, fetches in words 512..1023
        step();
        fork
            begin
                for (int n = 0; n < 120; n++) begin
                    logic [11:0] a;
                    int k;
                    a = {2'b00, 8'($urandom), 2'($urandom)};
                    k = $urandom_range(0, 9);
                    if (k < 4) data_txn(RW_READ, a, 4'h0, 32'h0);
                    else if (k < 9) data_txn(RW_WRITE, a, 4'($urandom_range(1, 15)), $urandom);
                    repeat ($urandom_range(0, 2)) step();
                end
            end
            begin
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(0, 5)) step();
                    fetch_txn({1'b1, 9'($urandom), 2'($urandom)});
                end
            end
        join

        repeat (5) step();
        check("d_queue_empty", d_q.size(), 0);
        check("f_queue_empty", f_q.size(), 0);
        nbad = 0;
        for (int i = 0; i < 1024; i++) if (ram_mem[i] !== ref_mem[i]) nbad++;
        check("ram_contents_bad_words", nbad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive data grants allowed while fetch waits before one forced fetch grant.
REQ-002 Clock is clk (one clock); reset is rst, synchronous and active-high.
REQ-003 clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-004 if_req  in  1  fetch request, level, held until if_ready; if_addr  in  12  byte address.
REQ-005 if_rdata  out  32  fetch word; if_ready  out  1  one-cycle completion pulse.
REQ-006 d_rw  in  2  01 write, 10 read, 11/00 idle; d_addr  in  12; d_sel  in  4  write byte mask; d_wdata  in  32.
REQ-007 d_rdata  out  32  read data; d_ready  out  1  completion pulse; d_err  out  1  misaligned-write pulse.
REQ-008 ram_en  out  1; ram_we  out  4; ram_addr  out  10  word address; ram_wdata  out  32; ram_rdata  in  32 (valid the cycle after ram_en).
REQ-009 stall_req  out  1  data access pending and not completing this cycle.

Function
REQ-010 FSM states IDLE, ACC_IF, ACC_D; one access per two cycles.
REQ-011 IDLE: data request (d_rw 01/10) wins, unless starve_cnt == STARVE_MAX and if_req high, then fetch wins.
REQ-012 Grant cycle: ram_en=1, ram_addr=addr[11:2]; next state ACC_IF or ACC_D; no grant -> stay IDLE, ram_en=0.
REQ-013 Data write grant: ram_we = d_sel << d_addr[1:0]; ram_wdata = d_wdata << 8*d_addr[1:0]; read/fetch grant: ram_we=0.
REQ-014 Misaligned write (any bit of d_sel shifted past bit 3): no RAM access, d_err and d_ready pulse one cycle after request seen, state stays IDLE.
REQ-015 ACC_IF: if_ready=1, if_rdata=ram_rdata; ACC_D: d_ready=1, d_rdata = ram_rdata >> 8*addr[1:0] (no extension); both -> IDLE.
REQ-016 Grant latency from IDLE: ready exactly 1 cycle after grant; address/data captured at grant, later input changes ignored.
REQ-017 starve_cnt (3 bits, saturating at STARVE_MAX): +1 on data grant while if_req high, clear on fetch grant or if_req low.
REQ-018 A port is never re-granted in the cycle its ready pulses (FSM returns to IDLE first).
REQ-019 stall_req = (d_rw is 01/10) and not d_ready; combinational.
REQ-020 Outputs not driven by the current state are 0 (rdata buses hold last value).

Reset
REQ-021 rst high at a clock edge: state IDLE, starve_cnt 0, ram_en/ram_we/if_ready/d_ready/d_err 0, rdata registers 0.
REQ-022 Reset mid-access abandons it with no ready pulse; a write already issued to RAM stays committed.

Structure
REQ-023 Shared package holds state encoding and d_rw codes (RW_WRITE 01, RW_READ 10, RW_IDLE 11).
REQ-024 One sub-module, mem_lane_align: combinational byte-lane shift for we/wdata/rdata and misalignment detect.

Verification
REQ-025 Write d_addr 0x005, d_sel 0001, d_wdata 0xAB -> ram_we 0010, ram_wdata 0x0000AB00, ram_addr 0x001, d_ready next cycle.
REQ-026 Read d_addr 0x006, ram_rdata 0x12345678 -> d_rdata 0x00001234, stall_req high in grant cycle, low in ready cycle.
REQ-027 if_req and continuous data reads, STARVE_MAX=4 -> 4 data grants then 1 fetch grant, starve_cnt cleared.
REQ-028 SW at d_addr 0x002 (sel 1111) -> d_err and d_ready pulse, ram_en never asserted.
REQ-029 rst asserted in ACC_D cycle -> no d_ready, state IDLE, all strobes 0 next cycle.
REQ-030 Simultaneous if_req and d_rw=10 with starve_cnt 0 -> data granted first, fetch granted two cycles later.
